// File: rtl/mem_dma_copier_if.sv
// Control and memory-strobe bundle between the copier and its neighbours.
// The shared data bus is a plain inout port on the copier itself.
interface mem_dma_copier_if;
    logic        start;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] remaining;
    logic [15:0] address;
    logic        en;
    logic        load_bar;

    modport master (
        input  start, src, dst, len,
        output busy, done, err, remaining,
        output address, en, load_bar
    );

    modport slave (
        output start, src, dst, len,
        input  busy, done, err, remaining,
        input  address, en, load_bar
    );
endinterface

// File: rtl/mem_dma_copier.sv
// Word-by-word block copier acting as a second initiator on the memory bus.
// Each word costs one READ cycle and one WRITE cycle; writes into ROM abort.
module mem_dma_copier #(
    parameter logic [15:0] ROM_TOP = 16'h00FF
) (
    input  logic              clk,
    input  logic              reset,
    mem_dma_copier_if.master  bif,
    inout  wire  [15:0]       bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state, state_nx;
    logic [15:0] rd_ptr, rd_nx;
    logic [15:0] wr_ptr, wr_nx;
    logic [15:0] remaining, rem_nx;
    logic [15:0] data, data_nx;
    logic        err_flag, err_nx;
    logic        done_flag, done_nx;
    logic        wr_legal;
    logic        drive;

    assign wr_legal = (wr_ptr > ROM_TOP);
    assign drive    = (state == WRITE) && wr_legal;

    // State register: only the FSM state lives here.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Datapath registers: pointers, word count, data latch and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= 16'h0000;
            wr_ptr    <= 16'h0000;
            remaining <= 16'h0000;
            data      <= 16'h0000;
            err_flag  <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            rd_ptr    <= rd_nx;
            wr_ptr    <= wr_nx;
            remaining <= rem_nx;
            data      <= data_nx;
            err_flag  <= err_nx;
            done_flag <= done_nx;
        end
    end

    // Next-state and next-datapath decode; done is a single-cycle pulse.
    always_comb begin
        state_nx = state;
        rd_nx    = rd_ptr;
        wr_nx    = wr_ptr;
        rem_nx   = remaining;
        data_nx  = data;
        err_nx   = err_flag;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bif.start) begin
                    rd_nx  = bif.src;
                    wr_nx  = bif.dst;
                    rem_nx = bif.len;
                    err_nx = 1'b0;
                    if (bif.len == 16'h0000) done_nx  = 1'b1;
                    else                     state_nx = READ;
                end
            end
            READ: begin
                data_nx  = bus;
                rd_nx    = rd_ptr + 16'd1;
                state_nx = WRITE;
            end
            WRITE: begin
                if (!wr_legal) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wr_nx  = wr_ptr + 16'd1;
                    rem_nx = remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = READ;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bus-side outputs decoded from registered state only.
    always_comb begin
        bif.address  = 16'h0000;
        bif.en       = 1'b0;
        bif.load_bar = 1'b1;
        unique case (state)
            READ: begin
                bif.address = rd_ptr;
                bif.en      = 1'b1;
            end
            WRITE: begin
                bif.address  = wr_ptr;
                bif.load_bar = !wr_legal;
            end
            default: ;
        endcase
    end

    assign bus           = drive ? data : 16'hzzzz;
    assign bif.busy      = (state != IDLE);
    assign bif.done      = done_flag;
    assign bif.err       = err_flag;
    assign bif.remaining = remaining;
endmodule

// File: tb/tb_mem_dma_copier.sv
// Bench for mem_dma_copier: memory model, protocol monitor,
// table of copy jobs plus reset and back-to-back sequences.
module tb_mem_dma_copier;
    logic clk = 1'b0;
    logic reset = 1'b1;
    wire [15:0] bus;

    mem_dma_copier_if bif();

    mem_dma_copier #(.ROM_TOP(16'h00FF)) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    int n_chk = 0;
    int n_fail = 0;

    assign bus = bif.en ? mem[bif.address] : 16'hzzzz;

    // Memory commits a write on the edge that ends a strobed cycle.
    always @(posedge clk) begin
        if (!bif.load_bar) mem[bif.address] <= bus;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [15:0] addr_pos;

    // Address snapshot just after each edge for the stability check.
    always @(posedge clk) begin
        #1 addr_pos = bif.address;
    end

    // Protocol monitor applied every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            chk("mon_en_wr_overlap", {31'd0, bif.en && !bif.load_bar}, 32'd0);
            if (bif.load_bar && !bif.en)
                chk("mon_bus_z", {31'd0, bus !== 16'hzzzz}, 32'd0);
            chk("mon_addr_stable", {16'd0, bif.address}, {16'd0, addr_pos});
        end
    end

    typedef struct packed {
        logic [15:0]       src;
        logic [15:0]       dst;
        logic [15:0]       len;
        logic [15:0]       chk_addr;
        logic [2:0]        nw;
        logic [3:0][15:0]  w;
        logic [7:0]        busy_c;
        logic [7:0]        done_c;
        logic [7:0]        wr_c;
        logic              err;
        logic [15:0]       rem;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0;
        int bc = 0;
        int dc = 0;
        int wc = 0;
        logic [15:0] a;
        @(negedge clk);
        bif.src = v.src;
        bif.dst = v.dst;
        bif.len = v.len;
        bif.start = 1'b1;
        @(posedge clk);
        #1 bif.start = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (bif.busy) bc++;
            if (bif.done) dc++;
            if (!bif.load_bar) wc++;
        end while (bif.busy && cyc < 64);
        chk($sformatf("v%0d_timeout", idx), {31'd0, bif.busy}, 32'd0);
        chk($sformatf("v%0d_err", idx), {31'd0, bif.err}, {31'd0, v.err});
        chk($sformatf("v%0d_rem", idx), {16'd0, bif.remaining}, {16'd0, v.rem});
        @(negedge clk);
        if (bif.done) dc++;
        chk($sformatf("v%0d_err_sticky", idx), {31'd0, bif.err}, {31'd0, v.err});
        chk($sformatf("v%0d_busy_cycles", idx), bc, {24'd0, v.busy_c});
        chk($sformatf("v%0d_done_pulses", idx), dc, {24'd0, v.done_c});
        chk($sformatf("v%0d_writes", idx), wc, {24'd0, v.wr_c});
        for (int i = 0; i < int'(v.nw); i++) begin
            a = v.chk_addr + 16'(i);
            chk($sformatf("v%0d_word%0d", idx, i), {16'd0, mem[a]},
                {16'd0, v.w[i]});
        end
    endtask

    initial begin
        bif.start = 1'b0;
        bif.src = 16'h0000;
        bif.dst = 16'h0000;
        bif.len = 16'h0000;
        for (int i = 0; i < 65536; i++)
            mem[i] = (i <= 255) ? (16'hC000 | 16'(i)) : 16'h0000;
        mem[16'h0200] = 16'h00A1;
        mem[16'h0201] = 16'h00B2;
        mem[16'h0202] = 16'h00C3;
        mem[16'h0500] = 16'h5151;
        mem[16'h0501] = 16'h5252;
        mem[16'hFFFF] = 16'h7777;
        mem[16'h0900] = 16'h0011;
        mem[16'h0901] = 16'h0022;
        mem[16'h0902] = 16'h0033;
        for (int i = 0; i < 8; i++) mem[16'h0600 + i] = 16'h6000 + 16'(i);

        vecs[0] = '{src:16'h0200, dst:16'h0300, len:16'd3, chk_addr:16'h0300,
                    nw:3'd3, w:{16'h0, 16'h00C3, 16'h00B2, 16'h00A1},
                    busy_c:8'd6, done_c:8'd1, wr_c:8'd3, err:1'b0, rem:16'd0};
        vecs[1] = '{src:16'h0010, dst:16'h0400, len:16'd2, chk_addr:16'h0400,
                    nw:3'd2, w:{16'h0, 16'h0, 16'hC011, 16'hC010},
                    busy_c:8'd4, done_c:8'd1, wr_c:8'd2, err:1'b0, rem:16'd0};
        vecs[2] = '{src:16'h0500, dst:16'h00FE, len:16'd2, chk_addr:16'h00FE,
                    nw:3'd2, w:{16'h0, 16'h0, 16'hC0FF, 16'hC0FE},
                    busy_c:8'd2, done_c:8'd0, wr_c:8'd0, err:1'b1, rem:16'd2};
        vecs[3] = '{src:16'hFFFF, dst:16'h1000, len:16'd2, chk_addr:16'h1000,
                    nw:3'd2, w:{16'h0, 16'h0, 16'hC000, 16'h7777},
                    busy_c:8'd4, done_c:8'd1, wr_c:8'd2, err:1'b0, rem:16'd0};
        vecs[4] = '{src:16'h0202, dst:16'hFFFF, len:16'd2, chk_addr:16'hFFFF,
                    nw:3'd2, w:{16'h0, 16'h0, 16'hC000, 16'h00C3},
                    busy_c:8'd4, done_c:8'd0, wr_c:8'd1, err:1'b1, rem:16'd1};
        vecs[5] = '{src:16'h0900, dst:16'h0901, len:16'd3, chk_addr:16'h0900,
                    nw:3'd4, w:{16'h0011, 16'h0011, 16'h0011, 16'h0011},
                    busy_c:8'd6, done_c:8'd1, wr_c:8'd3, err:1'b0, rem:16'd0};
        vecs[6] = '{src:16'h0200, dst:16'h0A00, len:16'd0, chk_addr:16'h0A00,
                    nw:3'd1, w:{16'h0, 16'h0, 16'h0, 16'h0000},
                    busy_c:8'd0, done_c:8'd1, wr_c:8'd0, err:1'b0, rem:16'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, bif.busy}, 32'd0);
        chk("rst_done", {31'd0, bif.done}, 32'd0);
        chk("rst_err", {31'd0, bif.err}, 32'd0);
        chk("rst_rem", {16'd0, bif.remaining}, 32'd0);
        chk("rst_addr", {16'd0, bif.address}, 32'd0);
        chk("rst_en", {31'd0, bif.en}, 32'd0);
        chk("rst_load_bar", {31'd0, bif.load_bar}, 32'd1);
        chk("rst_bus_z", {31'd0, bus !== 16'hzzzz}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset mid-copy with an ignored second start.
        @(negedge clk);
        bif.src = 16'h0600;
        bif.dst = 16'h0700;
        bif.len = 16'd8;
        bif.start = 1'b1;
        @(posedge clk);
        #1 bif.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bif.src = 16'h0200;
        bif.dst = 16'h0800;
        bif.len = 16'd1;
        bif.start = 1'b1;
        @(posedge clk);
        #1 bif.start = 1'b0;
        @(negedge clk);
        chk("mid_busy", {31'd0, bif.busy}, 32'd1);
        chk("mid_rem_ignored_start", {16'd0, bif.remaining}, 32'd7);
        chk("mid_addr", {16'd0, bif.address}, 32'h0701);
        chk("mid_load_bar", {31'd0, bif.load_bar}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mrst_busy", {31'd0, bif.busy}, 32'd0);
        chk("mrst_done", {31'd0, bif.done}, 32'd0);
        chk("mrst_err", {31'd0, bif.err}, 32'd0);
        chk("mrst_rem", {16'd0, bif.remaining}, 32'd0);
        chk("mrst_addr", {16'd0, bif.address}, 32'd0);
        chk("mrst_en", {31'd0, bif.en}, 32'd0);
        chk("mrst_load_bar", {31'd0, bif.load_bar}, 32'd1);
        chk("mrst_bus_z", {31'd0, bus !== 16'hzzzz}, 32'd0);
        chk("mrst_w0", {16'd0, mem[16'h0700]}, 32'h6000);
        chk("mrst_w1", {16'd0, mem[16'h0701]}, 32'h6001);
        chk("mrst_w2", {16'd0, mem[16'h0702]}, 32'h6002);
        chk("mrst_w3_untouched", {16'd0, mem[16'h0703]}, 32'h0000);
        chk("mrst_ignored_dst", {16'd0, mem[16'h0800]}, 32'h0000);

        // New start accepted in the same cycle done is high.
        @(negedge clk);
        bif.src = 16'h0200;
        bif.dst = 16'h0A00;
        bif.len = 16'd1;
        bif.start = 1'b1;
        @(posedge clk);
        #1 bif.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bif.done) break;
        end
        chk("b2b_first_done", {31'd0, bif.done}, 32'd1);
        bif.src = 16'h0201;
        bif.dst = 16'h0A01;
        bif.len = 16'd1;
        bif.start = 1'b1;
        @(posedge clk);
        #1 bif.start = 1'b0;
        @(negedge clk);
        chk("b2b_second_busy", {31'd0, bif.busy}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bif.done) break;
        end
        chk("b2b_second_done", {31'd0, bif.done}, 32'd1);
        chk("b2b_w0", {16'd0, mem[16'h0A00]}, 32'h00A1);
        chk("b2b_w1", {16'd0, mem[16'h0A01]}, 32'h00B2);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_dma_copier.md
# mem_dma_copier

Bus-master block that initiates read and write transactions on the shared 16-bit memory bus. It copies a block of words from a source address range to a destination address range using the memory's `en` (read-drive) and `load_bar` (write) protocol. It sits alongside the CPU as a second bus initiator. The CPU must not drive the bus, address, `en` or `load_bar` while `busy` is high.

## Interface
Parameters:
- `ROM_TOP`, default 16'h00FF: highest ROM address; any write at or below it is illegal.

Ports:
- `clk` input 1: single system clock; all state changes occur on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin a copy; sampled only in IDLE.
- `src` input 16: first source word address, latched on accepted `start`.
- `dst` input 16: first destination word address, latched on accepted `start`.
- `len` input 16: number of words to copy, latched on accepted `start`; 0 is legal.
- `busy` output 1: high from the cycle after an accepted `start` until the transfer ends.
- `done` output 1: one-cycle pulse on successful completion.
- `err` output 1: sticky; set when the copy is aborted by a ROM-region write; cleared by the next accepted `start` or by `reset`.
- `remaining` output 16: words not yet written.
- `address` output 16: memory address driven to Memory.
- `en` output 1: memory output-enable (read request), active high.
- `load_bar` output 1: memory write strobe, active low.
- `bus` inout 16: shared data bus; driven only in WRITE, Z otherwise.

## Operation
- **States**: IDLE, READ, WRITE.
- **IDLE**
  - `start`=1 latches `src`/`dst`/`len` into `rd_ptr`/`wr_ptr`/`remaining` and clears `err`.
  - If `len`=0, stay in IDLE and pulse `done` next cycle; `busy` never rises.
  - Otherwise go to READ.
- **READ**
  - Outputs: `address`=`rd_ptr`, `en`=1, `load_bar`=1, bus Z.
  - At the rising edge, capture `bus` into the data register, increment `rd_ptr`, and go to WRITE.
- **WRITE**
  - If `wr_ptr` <= `ROM_TOP` on entry, the write is illegal:
    - `load_bar` stays 1 and the bus stays Z for this cycle.
    - At the edge, set `err`=1, go to IDLE, and do not pulse `done`.
    - `remaining` keeps its value, indicating the number of words not written.
  - Otherwise:
    - Outputs: `address`=`wr_ptr`, `en`=0, `load_bar`=0, bus=data register.
    - At the edge: increment `wr_ptr` and decrement `remaining`.
    - If `remaining` becomes 0, go to IDLE and pulse `done`; otherwise go to READ.
- **Arithmetic**: pointers are 16 bits and wrap modulo 2^16 (FFFF -> 0000).
  - A source wrap into ROM is legal, since reads from ROM are allowed.
  - A destination wrap into ROM triggers the `err` abort.
- **Overlap**: the copy runs strictly forward, one word at a time (read N then write N).
  - With `dst` = `src`+k, 0<k<`len`, source data is overwritten before it is read, so the first k words replicate. This is the defined behaviour, not an error.
- `start` while `busy` is ignored; there is no queueing.
- **`reset`** in any state, including mid-transfer, gives: IDLE, `address`=0, `en`=0, `load_bar`=1, bus Z, `busy`=0, `done`=0, `err`=0, `remaining`=0, pointers 0.
  - A write in progress in the reset cycle is not guaranteed to complete.
- `en` and `load_bar`=0 are never asserted in the same cycle.
- All outputs are registered or decoded from state only; there are no combinational paths from `start` to bus outputs.

## Timing
- Start accept: `start` high at edge E0 means `busy`=1 and READ are active after E0.
- Each word takes exactly 2 cycles (READ, WRITE). A transfer of N words with no error has `busy` high for 2N cycles.
  - `done` is high in the cycle after the final WRITE edge, coincident with `busy`=0.
- Read data is sampled on the rising edge that ends READ. `address` and `en` are stable for the whole READ cycle.
- Memory commits the write at the rising edge ending WRITE. `address`, data and `load_bar` are stable for the whole WRITE cycle.
- Error abort: `err` rises and `busy` falls together, after the illegal WRITE cycle.
- The earliest new `start` is accepted in the same cycle `done` is high.

## Test plan
- Basic copy: RAM[0x0200..0x0202]=A1,B2,C3; start src=0x0200 dst=0x0300 len=3.
  - Expect RAM[0x0300..0x0302]=A1,B2,C3, `busy` high 6 cycles, one `done` pulse, `err`=0, `remaining`=0.
- ROM source: start src=0x0010 dst=0x0400 len=2.
  - Expect RAM[0x0400..0x0401] equal to ROM[0x10..0x11] and `done` pulsed.
- ROM destination: start src=0x0500 dst=0x00FE len=2.
  - Expect no write strobe ever, `err`=1 after 2 cycles, no `done`, `remaining`=2, ROM unchanged.
- Wrap and len=0:
  - start src=0xFFFF dst=0x1000 len=2 copies RAM[0xFFFF] then ROM[0x0000].
  - start len=0 gives `done` the next cycle with `busy` never high.
- Reset mid-copy plus ignored start: start len=8, pulse `start` again at cycle 3, assert `reset` at cycle 7.
  - Expect the second start ignored and all outputs at reset values the cycle after `reset`.
  - Expect the bus at Z, and at most 3 destination words written.
- Protocol monitor throughout all tests:
  - `en` and `load_bar`=0 never overlap.
  - The bus is driven only when `load_bar`=0.
  - `address` is stable within each cycle.
